mmio_controller: RTL and testbench

- Parametrised memory-mapped I/O block; replaces the fixed KEY/SW/HEX/LEDR/LEDG decode inside the data-memory path of the single-cycle core.
- Adds key/switch debouncing, a sticky key-press capture register and a programmable interval timer.
- Reads are combinational and side-effect free, so the single-cycle core can load in the same cycle.
- `hit` tells the top-level load mux to select `rdData` over RAM.

---
 rtl/mmio_pkg.sv | 38 +++
 rtl/debouncer.sv | 55 +++++
 rtl/seven_seg_decoder.sv | 32 +++
 rtl/mmio_controller.sv | 161 ++++++++++++++++
 tb/tb_mmio_controller.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets, timer control bits and glyphs for mmio_controller
package mmio_pkg;

  // Byte offsets inside the 64-byte I/O window
  localparam logic [5:0] OFF_HEX  = 6'h00;
  localparam logic [5:0] OFF_LEDR = 6'h04;
  localparam logic [5:0] OFF_LEDG = 6'h08;
  localparam logic [5:0] OFF_KEY  = 6'h10;
  localparam logic [5:0] OFF_SW   = 6'h14;
  localparam logic [5:0] OFF_KEYE = 6'h18;
  localparam logic [5:0] OFF_TCNT = 6'h20;
  localparam logic [5:0] OFF_TLIM = 6'h24;
  localparam logic [5:0] OFF_TCTL = 6'h28;

  // Timer control register bits
  localparam int TCTL_EN  = 0;
  localparam int TCTL_RDY = 1;
  localparam int TCTL_OVF = 2;

  // Active-low segments, bit6 = g ... bit0 = a
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/debouncer.sv
// rtl/debouncer.sv - two-flop synchroniser plus per-bit stability counter
module debouncer #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IDLE            = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] db_next_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Any sample equal to the debounced value restarts the count, so a bounce loses all progress
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Synchroniser, debounced value and counters; reset parks everything at the idle level
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= IDLE;
      s2_q <= IDLE;
      db_q <= IDLE;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      db_q <= db_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign db_o      = db_q;
  assign db_next_o = db_d;

endmodule

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - hex nibble to active-low seven-segment glyph
module seven_seg_decoder
  import mmio_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the sixteen hex glyphs
  always_comb begin
    seg_o = SEG_0;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      default: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/mmio_controller.sv
// rtl/mmio_controller.sv - memory-mapped KEY/SW/HEX/LED block with debouncing and interval timer
module mmio_controller
  import mmio_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_BASE       = 32'hF0000000,
  parameter int               N_HEX           = 4,
  parameter int               N_LEDR          = 10,
  parameter int               N_LEDG          = 8,
  parameter int               N_KEY           = 4,
  parameter int               N_SW            = 10,
  parameter int               DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DBITS-1:0]   addr,
  input  logic               wrEn,
  input  logic [DBITS-1:0]   wrData,
  output logic [DBITS-1:0]   rdData,
  output logic               hit,
  input  logic [N_KEY-1:0]   KEY,
  input  logic [N_SW-1:0]    SW,
  output logic [N_LEDR-1:0]  LEDR,
  output logic [N_LEDG-1:0]  LEDG,
  output logic [7*N_HEX-1:0] HEX
);

  logic [5:0] off;
  logic       wr;

  logic [4*N_HEX-1:0] hexv_q, hexv_d;
  logic [N_LEDR-1:0]  ledr_q, ledr_d;
  logic [N_LEDG-1:0]  ledg_q, ledg_d;
  logic [N_KEY-1:0]   keye_q, keye_d;
  logic [DBITS-1:0]   tcnt_q, tcnt_d;
  logic [DBITS-1:0]   tlim_q, tlim_d;
  logic               en_q, en_d, rdy_q, rdy_d, ovf_q, ovf_d;

  logic [N_KEY-1:0] key_db, key_db_next, keyd, press, keye_clr;
  logic [N_SW-1:0]  sw_db, sw_db_next;
  logic             tcnt_wr, tctl_wr;
  logic             unused_bits;

  assign off = {addr[5:2], 2'b00};
  assign hit = (addr[DBITS-1:6] == ADDR_BASE[DBITS-1:6]);
  assign wr  = wrEn && hit;

  debouncer #(
    .WIDTH(N_KEY), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE({N_KEY{1'b1}})
  ) u_key_db (
    .clk(clk), .reset(reset), .raw_i(KEY), .db_o(key_db), .db_next_o(key_db_next)
  );

  debouncer #(
    .WIDTH(N_SW), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE({N_SW{1'b0}})
  ) u_sw_db (
    .clk(clk), .reset(reset), .raw_i(SW), .db_o(sw_db), .db_next_o(sw_db_next)
  );

  // Keys are active-low; a press is captured on the same edge it becomes visible in KEYD
  assign keyd     = ~key_db;
  assign press    = key_db & ~key_db_next;
  assign keye_clr = (wr && off == OFF_KEYE) ? wrData[N_KEY-1:0] : '0;
  assign tcnt_wr  = wr && (off == OFF_TCNT);
  assign tctl_wr  = wr && (off == OFF_TCTL);

  // Next state for CPU-visible registers and the timer; sets beat same-cycle W1C clears
  always_comb begin
    hexv_d = hexv_q;
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    tlim_d = tlim_q;
    tcnt_d = tcnt_q;
    en_d   = en_q;
    rdy_d  = rdy_q;
    ovf_d  = ovf_q;
    keye_d = (keye_q & ~keye_clr) | press;

    if (wr && off == OFF_HEX)  hexv_d = wrData[4*N_HEX-1:0];
    if (wr && off == OFF_LEDR) ledr_d = wrData[N_LEDR-1:0];
    if (wr && off == OFF_LEDG) ledg_d = wrData[N_LEDG-1:0];
    if (wr && off == OFF_TLIM) tlim_d = wrData;

    if (tctl_wr) begin
      en_d  = wrData[TCTL_EN];
      rdy_d = rdy_q & ~wrData[TCTL_RDY];
      ovf_d = ovf_q & ~wrData[TCTL_OVF];
    end

    if (en_q) begin
      if (tcnt_q == tlim_q) begin
        tcnt_d = '0;
        // A CPU write to TCNT cancels the whole hit, flags included
        if (!tcnt_wr) begin
          rdy_d = 1'b1;
          if (rdy_q) ovf_d = 1'b1;
        end
      end else begin
        tcnt_d = tcnt_q + DBITS'(1);
      end
    end

    if (tcnt_wr) tcnt_d = wrData;
  end

  // Register file state
  always_ff @(posedge clk) begin
    if (!reset) begin
      hexv_q <= '0;
      ledr_q <= '0;
      ledg_q <= '0;
      keye_q <= '0;
      tcnt_q <= '0;
      tlim_q <= '0;
      en_q   <= 1'b0;
      rdy_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      hexv_q <= hexv_d;
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
      keye_q <= keye_d;
      tcnt_q <= tcnt_d;
      tlim_q <= tlim_d;
      en_q   <= en_d;
      rdy_q  <= rdy_d;
      ovf_q  <= ovf_d;
    end
  end

  // Side-effect-free read mux so the core can load in the same cycle
  always_comb begin
    rdData = '0;
    case (off)
      OFF_HEX:  rdData = DBITS'(hexv_q);
      OFF_LEDR: rdData = DBITS'(ledr_q);
      OFF_LEDG: rdData = DBITS'(ledg_q);
      OFF_KEY:  rdData = DBITS'(keyd);
      OFF_SW:   rdData = DBITS'(sw_db);
      OFF_KEYE: rdData = DBITS'(keye_q);
      OFF_TCNT: rdData = tcnt_q;
      OFF_TLIM: rdData = tlim_q;
      OFF_TCTL: rdData = DBITS'({ovf_q, rdy_q, en_q});
      default:  rdData = '0;
    endcase
  end

  for (genvar g = 0; g < N_HEX; g++) begin : g_hex
    seven_seg_decoder u_dec (
      .nibble_i(hexv_q[4*g +: 4]),
      .seg_o   (HEX[7*g +: 7])
    );
  end

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

  // Byte-lane bits and the next-value of the switch debouncer have no consumer here
  assign unused_bits = ^{addr[1:0], wrData, sw_db_next};

endmodule

// File: tb/tb_mmio_controller.sv
// tb/tb_mmio_controller.sv - scoreboard bench with randomized traffic against a behavioural model
module tb_mmio_controller;

  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'hF0000000;

  logic        clk = 1'b0;
  logic        reset, wrEn, hit;
  logic [31:0] addr, wrData, rdData;
  logic [3:0]  KEY;
  logic [9:0]  SW, LEDR;
  logic [7:0]  LEDG;
  logic [27:0] HEX;

  always #5 clk = ~clk;

  mmio_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrEn(wrEn), .wrData(wrData),
    .rdData(rdData), .hit(hit), .KEY(KEY), .SW(SW), .LEDR(LEDR), .LEDG(LEDG), .HEX(HEX)
  );

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  string       sb_name [$];
  int          sb_kind [$];
  logic [31:0] sb_exp  [$];
  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;
  logic [3:0]  key_drv;
  logic [9:0]  sw_drv;

  // Reference model state
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;
  logic [3:0]  m_keye;
  logic [31:0] m_tcnt, m_tlim;
  logic        m_en, m_rdy, m_ovf;
  logic [3:0]  k_db;
  logic [9:0]  s_db;
  logic [9:0]  kp [$];
  logic [9:0]  sp [$];
  logic [9:0]  kh [$];
  logic [9:0]  sh [$];

  function automatic bit m_hit(input logic [31:0] a);
    return (a >> 6) == (BASE >> 6);
  endfunction

  function automatic logic [31:0] rd_exp(input logic [31:0] a);
    case (a[5:0] & 6'h3C)
      6'h00:   return {16'b0, m_hex};
      6'h04:   return {22'b0, m_ledr};
      6'h08:   return {24'b0, m_ledg};
      6'h10:   return {28'b0, ~k_db};
      6'h14:   return {22'b0, s_db};
      6'h18:   return {28'b0, m_keye};
      6'h20:   return m_tcnt;
      6'h24:   return m_tlim;
      6'h28:   return {29'b0, m_ovf, m_rdy, m_en};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] hex_exp();
    logic [31:0] h;
    h = '0;
    for (int i = 0; i < 4; i++) h[7*i +: 7] = glyph[m_hex[4*i +: 4]];
    return h;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, e);
    end
  endtask

  task automatic push(input string n, input int k, input logic [31:0] e);
    sb_name.push_back(n);
    sb_kind.push_back(k);
    sb_exp.push_back(e);
  endtask

  // Advance the model by one clock edge using the inputs that were present before it
  task automatic model_update(input bit rst, input bit we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] key, input logic [9:0] sw);
    bit          w, all, tw;
    logic [5:0]  o;
    logic [3:0]  kdb_n;
    logic [9:0]  sdb_n;
    logic [31:0] tc_n;
    logic        en_n, rdy_n, ovf_n;
    if (!rst) begin
      m_hex = '0; m_ledr = '0; m_ledg = '0; m_keye = '0;
      m_tcnt = '0; m_tlim = '0; m_en = 0; m_rdy = 0; m_ovf = 0;
      k_db = 4'hF; s_db = '0;
      kp.delete(); kp.push_back(10'h00F); kp.push_back(10'h00F);
      sp.delete(); sp.push_back(10'h000); sp.push_back(10'h000);
      kh.delete(); sh.delete();
      return;
    end
    w = we && m_hit(a);
    o = a[5:0] & 6'h3C;
    // Inputs reach the debouncer two edges late; a level flips after D straight samples against it
    kh.push_back(kp.pop_front()); kp.push_back({6'b0, key});
    sh.push_back(sp.pop_front()); sp.push_back(sw);
    if (kh.size() > D) void'(kh.pop_front());
    if (sh.size() > D) void'(sh.pop_front());
    kdb_n = k_db;
    sdb_n = s_db;
    if (kh.size() == D) begin
      for (int b = 0; b < 4; b++) begin
        all = 1;
        foreach (kh[j]) if (kh[j][b] == k_db[b]) all = 0;
        if (all) kdb_n[b] = ~k_db[b];
      end
    end
    if (sh.size() == D) begin
      for (int b = 0; b < 10; b++) begin
        all = 1;
        foreach (sh[j]) if (sh[j][b] == s_db[b]) all = 0;
        if (all) sdb_n[b] = ~s_db[b];
      end
    end
    // Timer rules
    tw = w && o == 6'h20;
    en_n = m_en; rdy_n = m_rdy; ovf_n = m_ovf; tc_n = m_tcnt;
    if (w && o == 6'h28) begin
      en_n  = d[0];
      rdy_n = m_rdy & ~d[1];
      ovf_n = m_ovf & ~d[2];
    end
    if (m_en) begin
      if (m_tcnt == m_tlim) begin
        tc_n = 0;
        if (!tw) begin
          rdy_n = 1;
          if (m_rdy) ovf_n = 1;
        end
      end else begin
        tc_n = m_tcnt + 1;
      end
    end
    if (tw) tc_n = d;
    if (w && o == 6'h24) m_tlim = d;
    if (w && o == 6'h00) m_hex  = d[15:0];
    if (w && o == 6'h04) m_ledr = d[9:0];
    if (w && o == 6'h08) m_ledg = d[7:0];
    m_keye = (m_keye & ~((w && o == 6'h18) ? d[3:0] : 4'h0)) | (k_db & ~kdb_n);
    k_db = kdb_n; s_db = sdb_n;
    m_tcnt = tc_n; m_en = en_n; m_rdy = rdy_n; m_ovf = ovf_n;
  endtask

  // Drive one cycle, queue the expected outputs, then advance the model across the edge
  task automatic step(input bit rst, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
    reset = rst; wrEn = we; addr = a; wrData = d; KEY = key_drv; SW = sw_drv;
    if (chk_en) begin
      push({tag, ".hit"}, 1, {31'b0, m_hit(a)});
      if (m_hit(a)) push({tag, ".rd"}, 0, rd_exp(a));
      push({tag, ".ledr"}, 2, {22'b0, m_ledr});
      push({tag, ".ledg"}, 3, {24'b0, m_ledg});
      push({tag, ".hex"}, 4, hex_exp());
    end
    @(posedge clk);
    model_update(rst, we, a, d, key_drv, sw_drv);
    #1;
  endtask

  task automatic rd(input logic [5:0] o, input string tag);
    step(1, 0, BASE + {26'b0, o}, $urandom, tag);
  endtask

  task automatic wrr(input logic [5:0] o, input logic [31:0] d, input string tag);
    step(1, 1, BASE + {26'b0, o}, d, tag);
  endtask

  // Monitor: compares every queued expectation against the DUT mid-cycle
  always @(negedge clk) begin
    string       n;
    int          k;
    logic [31:0] e, act;
    while (sb_kind.size() > 0) begin
      n = sb_name.pop_front();
      k = sb_kind.pop_front();
      e = sb_exp.pop_front();
      case (k)
        0:       act = rdData;
        1:       act = {31'b0, hit};
        2:       act = {22'b0, LEDR};
        3:       act = {24'b0, LEDG};
        default: act = {4'b0, HEX};
      endcase
      check(n, act, e);
    end
  end

  initial begin
    logic [5:0]  offs [8] = '{6'h00, 6'h04, 6'h08, 6'h18, 6'h20, 6'h24, 6'h28, 6'h3C};
    logic [5:0]  o;
    logic [31:0] d;
    int          r;
    int          waited;
    key_drv = 4'hF;
    sw_drv  = '0;

    // 1. Reset
    step(0, 0, BASE, 0, "rst_a");
    chk_en = 1;
    step(0, 0, BASE + 32'h28, 0, "rst_b");
    reset = 1'b1;
    addr  = BASE + 32'h14;
    #1;
    check("rst_ledr_direct", {22'b0, LEDR}, 32'h0);
    check("rst_ledg_direct", {24'b0, LEDG}, 32'h0);
    check("rst_hex_direct", {4'b0, HEX}, 32'h08102040);
    check("rst_hit_direct", {31'b0, hit}, 32'h1);
    push("rst_hex_const", 4, 32'h08102040);
    step(1, 0, BASE + 32'h14, 0, "rst_hit");
    rd(6'h28, "rst_tctl");
    step(1, 0, 32'hE0000014, 0, "miss_hit");

    // 2. Store / read-back
    wrr(6'h00, 32'h1234, "hex_wr");
    push("hex_1234_const", 4, {4'b0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    rd(6'h00, "hex_rd");
    wrr(6'h04, 32'hFFFF_F2A5, "ledr_wr");
    wrr(6'h08, 32'h0000_015A, "ledg_wr");
    wrr(6'h3C, 32'hFFFF_FFFF, "unmapped_wr");
    rd(6'h3C, "unmapped_rd");
    step(1, 1, 32'h7000_0004, 32'h1, "miss_wr");
    rd(6'h04, "ledr_rd");

    // 3. Clean press, release, then bouncing input
    key_drv = 4'hE;
    for (int i = 0; i < 8; i++) rd((i % 2) ? 6'h18 : 6'h10, "press");
    key_drv = 4'hF;
    for (int i = 0; i < 8; i++) rd(6'h10, "release");
    for (int i = 0; i < 20; i++) begin
      key_drv = ((i / 2) % 2) ? 4'hF : 4'hE;
      rd(6'h10, "bounce");
    end
    key_drv = 4'hF;
    for (int i = 0; i < 8; i++) rd(6'h10, "settle");
    wrr(6'h18, 32'hF, "keye_clr0");

    // 4. KEYE clear colliding with press edge, then clear alone
    key_drv = 4'hE;
    for (int i = 0; i < 5; i++) rd(6'h10, "pre_edge");
    wrr(6'h18, 32'h1, "keye_clr_at_edge");
    rd(6'h18, "keye_set_wins");
    wrr(6'h18, 32'h1, "keye_clr");
    rd(6'h18, "keye_cleared");
    key_drv = 4'hF;
    for (int i = 0; i < 8; i++) rd(6'h10, "settle2");

    // 5. Timer
    wrr(6'h24, 32'd3, "tlim_wr");
    wrr(6'h20, 32'd0, "tcnt_wr");
    wrr(6'h28, 32'd1, "tctl_wr");
    for (int i = 0; i < 5; i++) rd(6'h20, "tcnt_seq");
    rd(6'h28, "rdy_set");
    for (int i = 0; i < 4; i++) rd(6'h20, "tcnt_run");
    rd(6'h28, "ovf_set");
    wrr(6'h28, 32'd7, "tctl_w1c");
    rd(6'h28, "tctl_after_w1c");
    for (int i = 0; i < 6; i++) rd(6'h28, "tctl_run");
    wrr(6'h24, 32'd0, "tlim_zero");
    for (int i = 0; i < 3; i++) rd(6'h28, "tlim0");
    wrr(6'h20, 32'hFFFF_FFFE, "tcnt_near_wrap");
    wrr(6'h24, 32'd5, "tlim5");
    for (int i = 0; i < 4; i++) rd(6'h20, "wrap");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) key_drv = 4'($urandom);
      if ($urandom_range(0, 5) == 0) sw_drv = 10'($urandom);
      r = $urandom_range(0, 99);
      o = offs[$urandom_range(0, 7)] | 6'($urandom_range(0, 3));
      d = $urandom;
      if ((o & 6'h3C) == 6'h24) d = $urandom_range(0, 6);
      if ((o & 6'h3C) == 6'h20 && d[0]) d = $urandom_range(0, 4);
      if (r == 0)       step(0, 0, BASE, 0, "rnd_rst");
      else if (r < 35)  step(1, 1, BASE + {26'b0, o}, d, "rnd_wr");
      else if (r < 42)  step(1, 1, {4'hA, 28'($urandom)}, d, "rnd_miss");
      else              step(1, 0, BASE + {26'b0, 6'($urandom)}, d, "rnd_rd");
    end

    // 6. Reset while the timer runs and a key is held
    key_drv = 4'hF;
    for (int i = 0; i < 8; i++) rd(6'h10, "settle3");
    wrr(6'h24, 32'd100, "tlim100");
    wrr(6'h28, 32'd1, "tctl_en");
    key_drv = 4'hE;
    for (int i = 0; i < 10; i++) rd(6'h20, "run_held");
    step(0, 0, BASE + 32'h20, 0, "mid_rst");
    rd(6'h20, "post_rst_tcnt");
    rd(6'h28, "post_rst_tctl");
    rd(6'h18, "post_rst_keye");
    for (int i = 0; i < 6; i++) rd(6'h10, "post_rst_keyd");

    // Bounded wait for the held key to reappear in KEYD
    waited = 0;
    addr   = BASE + 32'h10;
    wrEn   = 1'b0;
    #1;
    while (rdData !== 32'h1 && waited < 12) begin
      rd(6'h10, "keyd_wait");
      waited++;
    end
    check("keyd_wait_expired", {31'b0, (waited < 12)}, 32'h1);
    check("keyd_after_wait", rdData, 32'h1);

    step(1, 0, BASE, 0, "tail");
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
